// File: rtl/if_instr_queue_pkg.sv
// Shared definitions for the fetch-side instruction queue: reset PC, zero
// constants, default depth and the drop counter width.
package if_instr_queue_pkg;

    localparam logic [63:0] BASE_PC     = 64'h0000_0000_8000_0000;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
    localparam logic [63:0] ZERO_DOUBLE = 64'h0000_0000_0000_0000;
    localparam int unsigned IQ_DEPTH    = 4;
    localparam int unsigned DROP_CNT_W  = 16;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } iq_entry_t;

endpackage

// File: rtl/iq_ram.sv
// DEPTH x 96-bit queue storage: two independent write ports (one per word of
// a fetched beat) and one asynchronous read port for the queue head.
module iq_ram
    import if_instr_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we0_i,
    input  logic [AW-1:0]   waddr0_i,
    input  iq_entry_t       wdata0_i,
    input  logic            we1_i,
    input  logic [AW-1:0]   waddr1_i,
    input  iq_entry_t       wdata1_i,
    input  logic [AW-1:0]   raddr_i,
    output iq_entry_t       rdata_o
);

    iq_entry_t mem_q [DEPTH];

    // Storage write; the control never aims both ports at the same entry.
    always_ff @(posedge clk) begin
        if (we0_i) begin
            mem_q[waddr0_i] <= wdata0_i;
        end
        if (we1_i) begin
            mem_q[waddr1_i] <= wdata1_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_instr_queue.sv
// Fetch instruction queue: splits 64-bit fetch beats into 32-bit instructions,
// drops beats whose PC is not the expected one, and flushes on redirect.
module if_instr_queue
    import if_instr_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  beat_valid,
    input  logic [63:0]           beat_data,
    input  logic [63:0]           beat_pc,
    output logic                  beat_ready,
    input  logic                  flush,
    input  logic [63:0]           redirect_pc,
    output logic                  instr_valid,
    output logic [31:0]           instr,
    output logic [63:0]           instr_pc,
    input  logic                  instr_ready,
    output logic [63:0]           expect_pc,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [63:0]           expect_pc_q, expect_pc_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic                  not_empty_s, pop_s, accept_s, hit_s, two_s, ready_s;
    logic [1:0]            push_n_s;
    logic [CNT_W:0]        room_s;
    iq_entry_t             wdata0_s, wdata1_s, head_s;

    // Handshake, push decode and next-state; flush overrides push and pop.
    always_comb begin
        not_empty_s = (count_q != {CNT_W{1'b0}});
        pop_s       = not_empty_s & instr_ready;
        // Free space after this cycle's pop must fit a whole two-word beat.
        room_s      = (CNT_W+1)'(DEPTH) - {1'b0, count_q} + {{CNT_W{1'b0}}, pop_s};
        ready_s     = rst_n & ~flush & (room_s >= (CNT_W+1)'(2));
        accept_s    = beat_valid & ready_s;
        hit_s       = accept_s & (beat_pc == expect_pc_q);
        two_s       = hit_s & ~beat_pc[2];
        push_n_s    = two_s ? 2'd2 : (hit_s ? 2'd1 : 2'd0);

        wdata0_s.instr = beat_pc[2] ? beat_data[63:32] : beat_data[31:0];
        wdata0_s.pc    = beat_pc;
        wdata1_s.instr = beat_data[63:32];
        wdata1_s.pc    = beat_pc + 64'd4;

        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        expect_pc_d = expect_pc_q;
        drop_cnt_d  = drop_cnt_q;
        if (flush) begin
            rd_ptr_d    = {PTR_W{1'b0}};
            wr_ptr_d    = {PTR_W{1'b0}};
            count_d     = {CNT_W{1'b0}};
            expect_pc_d = redirect_pc;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
            wr_ptr_d = wr_ptr_q + PTR_W'(push_n_s);
            count_d  = count_q + CNT_W'(push_n_s) - CNT_W'(pop_s);
            if (hit_s) begin
                expect_pc_d = expect_pc_q + (two_s ? 64'd8 : 64'd4);
            end else begin
                expect_pc_d = expect_pc_q;
            end
            if (accept_s && !hit_s && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
                drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end
    end

    // Pointer, occupancy, expected-PC and drop counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= {PTR_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            expect_pc_q <= BASE_PC;
            drop_cnt_q  <= {DROP_CNT_W{1'b0}};
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            expect_pc_q <= expect_pc_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    iq_ram #(
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_iq_ram (
        .clk      (clk),
        .we0_i    (hit_s),
        .waddr0_i (wr_ptr_q),
        .wdata0_i (wdata0_s),
        .we1_i    (two_s),
        .waddr1_i (wr_ptr_q + PTR_W'(1)),
        .wdata1_i (wdata1_s),
        .raddr_i  (rd_ptr_q),
        .rdata_o  (head_s)
    );

    assign beat_ready  = ready_s;
    assign instr_valid = not_empty_s;
    assign instr       = not_empty_s ? head_s.instr : ZERO_WORD;
    assign instr_pc    = not_empty_s ? head_s.pc : ZERO_DOUBLE;
    assign expect_pc   = expect_pc_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_if_instr_queue.sv
// Bench for if_instr_queue: table of per-cycle vectors plus hand sequences,
// with a scoreboard of expected instructions popped as decode consumes them.
module tb_if_instr_queue;

    localparam int DEPTH = 4;
    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        beat_valid;
    logic [63:0] beat_data;
    logic [63:0] beat_pc;
    logic        beat_ready;
    logic        flush;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready;
    logic [63:0] expect_pc;
    logic [15:0] drop_cnt;

    if_instr_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .beat_valid  (beat_valid),
        .beat_data   (beat_data),
        .beat_pc     (beat_pc),
        .beat_ready  (beat_ready),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .expect_pc   (expect_pc),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] i;
        logic [63:0] p;
    } ent_t;

    typedef struct {
        logic        bv;
        logic [63:0] bpc;
        logic [63:0] bd;
        logic        fl;
        logic [63:0] rpc;
        logic        ir;
        logic        er;
        logic        ev;
    } vec_t;

    ent_t        sb[$];
    logic [63:0] exp_pc_m;
    logic [15:0] drop_m;
    int          checks = 0;
    int          failures = 0;
    vec_t        vecs[18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, check combinational outputs mid-cycle,
    // advance the model, then check registered state after the edge.
    task automatic cyc(input logic bv, input logic [63:0] bpc, input logic [63:0] bd,
                       input logic fl, input logic [63:0] rpc, input logic ir,
                       input logic use_tbl, input logic er, input logic ev);
        logic pop_m, rdy_m;
        ent_t e;
        beat_valid = bv; beat_pc = bpc; beat_data = bd;
        flush = fl; redirect_pc = rpc; instr_ready = ir;
        #3;
        pop_m = (sb.size() != 0) && ir;
        rdy_m = !fl && ((DEPTH - sb.size() + int'(pop_m)) >= 2);
        chk("beat_ready", {63'd0, beat_ready}, {63'd0, rdy_m});
        chk("instr_valid", {63'd0, instr_valid}, {63'd0, sb.size() != 0});
        if (use_tbl) begin
            chk("tbl_beat_ready", {63'd0, beat_ready}, {63'd0, er});
            chk("tbl_instr_valid", {63'd0, instr_valid}, {63'd0, ev});
        end
        if (sb.size() != 0) begin
            chk("instr", {32'd0, instr}, {32'd0, sb[0].i});
            chk("instr_pc", instr_pc, sb[0].p);
        end else begin
            chk("instr_empty", {32'd0, instr}, 64'd0);
            chk("instr_pc_empty", instr_pc, 64'd0);
        end
        if (fl) begin
            sb.delete();
            exp_pc_m = rpc;
        end else begin
            if (pop_m) void'(sb.pop_front());
            if (bv && rdy_m) begin
                if (bpc == exp_pc_m) begin
                    if (bpc[2]) begin
                        e.i = bd[63:32]; e.p = bpc; sb.push_back(e);
                        exp_pc_m = exp_pc_m + 64'd4;
                    end else begin
                        e.i = bd[31:0]; e.p = bpc; sb.push_back(e);
                        e.i = bd[63:32]; e.p = bpc + 64'd4; sb.push_back(e);
                        exp_pc_m = exp_pc_m + 64'd8;
                    end
                end else if (drop_m != 16'hFFFF) begin
                    drop_m = drop_m + 16'd1;
                end
            end
        end
        @(posedge clk); #1;
        chk("expect_pc", expect_pc, exp_pc_m);
        chk("drop_cnt", {48'd0, drop_cnt}, {48'd0, drop_m});
    endtask

    task automatic idle(input logic ir);
        cyc(1'b0, 64'd0, 64'd0, 1'b0, 64'd0, ir, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        //          bv    bpc                     bd                      fl    rpc                     ir    er    ev
        vecs[0]  = '{1'b1, 64'h8000_0000, 64'h1111_1111_2222_2222, 1'b0, 64'd0,           1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 64'd0,         64'd0,                   1'b0, 64'd0,           1'b1, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 64'd0,         64'd0,                   1'b0, 64'd0,           1'b1, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 64'd0,         64'd0,                   1'b0, 64'd0,           1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 64'h8000_0000, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'h8000_0104,   1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 64'h8000_0104, 64'hAAAA_AAAA_BBBB_BBBB, 1'b0, 64'd0,           1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 64'h8000_0108, 64'h3333_3333_4444_4444, 1'b0, 64'd0,           1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 64'h8000_0110, 64'h7777_7777_8888_8888, 1'b0, 64'd0,           1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 64'd0,         64'd0,                   1'b0, 64'd0,           1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 64'h8000_0108, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 64'd0,           1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 64'h8000_0110, 64'h5555_5555_6666_6666, 1'b0, 64'd0,           1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 64'd0,         64'd0,                   1'b0, 64'd0,           1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 64'd0,         64'd0,                   1'b0, 64'd0,           1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 64'd0,         64'd0,                   1'b0, 64'd0,           1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 64'd0,         64'd0,                   1'b0, 64'd0,           1'b1, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 64'd0,         64'd0,                   1'b0, 64'd0,           1'b1, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 64'd0,         64'd0,                   1'b0, 64'd0,           1'b1, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 64'd0,         64'd0,                   1'b0, 64'd0,           1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; beat_valid = 1'b0; beat_pc = 64'd0; beat_data = 64'd0;
        flush = 1'b0; redirect_pc = 64'd0; instr_ready = 1'b0;
        exp_pc_m = BASE; drop_m = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        beat_valid = 1'b1; beat_pc = BASE;
        #1;
        chk("rst_beat_ready", {63'd0, beat_ready}, 64'd0);
        chk("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_instr", {32'd0, instr}, 64'd0);
        chk("rst_expect_pc", expect_pc, BASE);
        chk("rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
        beat_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int k = 0; k < 18; k++) begin
            cyc(vecs[k].bv, vecs[k].bpc, vecs[k].bd, vecs[k].fl, vecs[k].rpc,
                vecs[k].ir, 1'b1, vecs[k].er, vecs[k].ev);
        end
        chk("drop_after_stale", {48'd0, drop_cnt}, 64'd1);
        chk("expect_after_table", expect_pc, 64'h8000_0118);

        // Flush while a push and a pop are also requested, three entries queued.
        cyc(1'b1, 64'h8000_0118, 64'hCAFE_0001_CAFE_0000, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'h8000_0120, 64'hCAFE_0003_CAFE_0002, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_flush_count3", sb.size(), 64'd3);
        cyc(1'b1, 64'h8000_0128, 64'hCAFE_0005_CAFE_0004, 1'b1, 64'h9000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_flush_valid", {63'd0, instr_valid}, 64'd0);
        chk("post_flush_drop", {48'd0, drop_cnt}, 64'd1);
        chk("post_flush_expect", expect_pc, 64'h9000_0000);
        idle(1'b0);

        // 64-bit PC wrap across the top of the address space.
        cyc(1'b0, 64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0BAD_F00D_600D_F00D, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_expect", expect_pc, 64'd0);
        idle(1'b1);
        idle(1'b1);

        // Reset pulsed mid-stream with two entries queued.
        cyc(1'b1, 64'd0, 64'h0000_0002_0000_0001, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_valid", {63'd0, instr_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {63'd0, instr_valid}, 64'd0);
        chk("midrst_instr", {32'd0, instr}, 64'd0);
        chk("midrst_beat_ready", {63'd0, beat_ready}, 64'd0);
        chk("midrst_expect_pc", expect_pc, BASE);
        chk("midrst_drop", {48'd0, drop_cnt}, 64'd0);
        sb.delete(); exp_pc_m = BASE; drop_m = 16'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
